// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
// Write-back scheduler and busy-register scoreboard for the 32x32 MIPS
// register file. The ALU result path and the load result path share the
// single register-file write port; the scoreboard flags decode-stage
// operands whose producer has not yet written back.
//
// Optional feature macro: WB_RR_EN
//   defined   : round-robin between ALU and load paths when both are valid
//   undefined : fixed priority, load path always wins (no last-grant state)

module regfile_wb_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueRegister,
  output logic                  issueReady,

  input  logic [ADDR_WIDTH-1:0] register1,
  input  logic [ADDR_WIDTH-1:0] register2,
  output logic                  hazard,

  input  logic                  aluValid,
  input  logic [ADDR_WIDTH-1:0] aluRegister,
  input  logic [DATA_WIDTH-1:0] aluData,
  output logic                  aluReady,

  input  logic                  memValid,
  input  logic [ADDR_WIDTH-1:0] memRegister,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic                  memReady,

  output logic                  regWrite,
  output logic [ADDR_WIDTH-1:0] writeRegister,
  output logic [DATA_WIDTH-1:0] writeData
);

  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  logic                  grant_alu;
  logic                  grant_mem;
  logic                  xfer;
  logic                  xfer_write;
  logic [ADDR_WIDTH-1:0] xfer_reg;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  issue_take;

  // ---------------------------------------------------------------------
  // Arbitration between the ALU and load write-back requesters
  // ---------------------------------------------------------------------
`ifdef WB_RR_EN
  // 1 = load path held the write port most recently
  logic last_grant_mem;

  // Remember which requester won the last transfer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_mem <= 1'b1;
    end else if (grant_mem) begin
      last_grant_mem <= 1'b1;
    end else if (grant_alu) begin
      last_grant_mem <= 1'b0;
    end
  end

  // Round-robin: on contention the requester not granted last wins
  always_comb begin
    grant_alu = aluValid & (~memValid | last_grant_mem);
    grant_mem = memValid & (~aluValid | ~last_grant_mem);
  end
`else
  // Fixed priority: the load path always beats the ALU path
  always_comb begin
    grant_mem = memValid;
    grant_alu = aluValid & ~memValid;
  end
`endif

  assign aluReady = grant_alu;
  assign memReady = grant_mem;

  // Select the winning requester's destination and data
  always_comb begin
    xfer      = grant_alu | grant_mem;
    xfer_reg  = grant_mem ? memRegister : aluRegister;
    xfer_data = grant_mem ? memData     : aluData;
    // Writes to register 0 are swallowed: accepted but never presented
    xfer_write = xfer & (xfer_reg != '0);
  end

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  assign issueReady = issueValid & ~busy[issueRegister];
  assign issue_take = issueReady & (issueRegister != '0);

  // Operand hazard: register 0 is never pending
  assign hazard = ((register1 != '0) & busy[register1]) |
                  ((register2 != '0) & busy[register2]);

  // Next busy vector: write-back clears, accepted reservation sets
  always_comb begin
    busy_next = busy;
    if (xfer_write) begin
      busy_next[xfer_reg] = 1'b0;
    end
    // A reservation can only land on a non-busy register, so it never
    // collides with a clear of a genuinely pending entry; if it meets a
    // write to an already idle register, the new reservation must survive.
    if (issue_take) begin
      busy_next[issueRegister] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // ---------------------------------------------------------------------
  // Register-file write port, one cycle after the transfer
  // ---------------------------------------------------------------------
  // Pulse regWrite per transfer; index and data hold between writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      regWrite <= xfer_write;
      if (xfer_write) begin
        writeRegister <= xfer_reg;
        writeData     <= xfer_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed, table-driven bench for regfile_wb_scheduler.
// Expectations for the contention vectors follow WB_RR_EN when defined.

module tb_regfile_wb_scheduler;

  logic        clock;
  logic        reset;
  logic        issueValid;
  logic [4:0]  issueRegister;
  logic        issueReady;
  logic [4:0]  register1;
  logic [4:0]  register2;
  logic        hazard;
  logic        aluValid;
  logic [4:0]  aluRegister;
  logic [31:0] aluData;
  logic        aluReady;
  logic        memValid;
  logic [4:0]  memRegister;
  logic [31:0] memData;
  logic        memReady;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;

  int tests_run;
  int tests_failed;

  regfile_wb_scheduler #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .clock(clock), .reset(reset),
    .issueValid(issueValid), .issueRegister(issueRegister), .issueReady(issueReady),
    .register1(register1), .register2(register2), .hazard(hazard),
    .aluValid(aluValid), .aluRegister(aluRegister), .aluData(aluData), .aluReady(aluReady),
    .memValid(memValid), .memRegister(memRegister), .memData(memData), .memReady(memReady),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        e_ir;
    logic        e_hz;
    logic        e_ar;
    logic        e_mr;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n,
                     input logic iv, input logic [4:0] ir,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mr, input logic [31:0] md,
                     input logic e_ir, input logic e_hz, input logic e_ar, input logic e_mr,
                     input logic e_rw, input logic [4:0] e_wr, input logic [31:0] e_wd);
    vec_t v;
    v.name = n; v.iv = iv; v.ir = ir; v.r1 = r1; v.r2 = r2;
    v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.e_ir = e_ir; v.e_hz = e_hz; v.e_ar = e_ar; v.e_mr = e_mr;
    v.e_rw = e_rw; v.e_wr = e_wr; v.e_wd = e_wd;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    issueValid = 0; issueRegister = 0; register1 = 0; register2 = 0;
    aluValid = 0; aluRegister = 0; aluData = 0;
    memValid = 0; memRegister = 0; memData = 0;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clock);
    issueValid = v.iv; issueRegister = v.ir; register1 = v.r1; register2 = v.r2;
    aluValid = v.av; aluRegister = v.ar; aluData = v.ad;
    memValid = v.mv; memRegister = v.mr; memData = v.md;
    #1;
    check({v.name, ".issueReady"}, 32'(issueReady), 32'(v.e_ir));
    check({v.name, ".hazard"},     32'(hazard),     32'(v.e_hz));
    check({v.name, ".aluReady"},   32'(aluReady),   32'(v.e_ar));
    check({v.name, ".memReady"},   32'(memReady),   32'(v.e_mr));
    @(posedge clock);
    #1;
    check({v.name, ".regWrite"},      32'(regWrite),      32'(v.e_rw));
    check({v.name, ".writeRegister"}, 32'(writeRegister), 32'(v.e_wr));
    check({v.name, ".writeData"},     32'(writeData),     v.e_wd);
  endtask

  initial begin
    logic [4:0]  w2;
    logic [31:0] d2;
    tests_run = 0;
    tests_failed = 0;
    idle_inputs();
    reset = 1'b1;
    register1 = 5'd8;

    w2 = RR ? 5'd10 : 5'd9;
    d2 = RR ? 32'h0000_1010 : 32'h0000_0099;

    //   name   iv ir  r1 r2  av ar ad            mv mr  md             ir hz ar mr  rw wr  wd
    add("v01", 0, 0,  0, 0,  0, 0, 0,            0, 0,  0,             0, 0, 0, 0,  0, 0,  0);
    add("v02", 1, 8,  8, 0,  0, 0, 0,            0, 0,  0,             1, 0, 0, 0,  0, 0,  0);
    add("v03", 1, 8,  8, 0,  0, 0, 0,            0, 0,  0,             0, 1, 0, 0,  0, 0,  0);
    add("v04", 0, 0,  8, 0,  1, 8, 32'hAB,       0, 0,  0,             0, 1, 1, 0,  1, 8,  32'hAB);
    add("v05", 0, 0,  8, 0,  0, 0, 0,            0, 0,  0,             0, 0, 0, 0,  0, 8,  32'hAB);
    add("v06", 0, 0,  0, 0,  0, 0, 0,            1, 0,  32'hFFFF_FFFF, 0, 0, 0, 1,  0, 8,  32'hAB);
    add("v07", 1, 9,  0, 0,  0, 0, 0,            0, 0,  0,             1, 0, 0, 0,  0, 8,  32'hAB);
    add("v08", 1, 10, 9, 0,  0, 0, 0,            0, 0,  0,             1, 1, 0, 0,  0, 8,  32'hAB);
    if (!RR) begin
      add("v09", 0, 0, 9, 10, 1, 9, 32'h99,     1, 10, 32'h1010,      0, 1, 0, 1,  1, 10, 32'h1010);
      add("v10", 0, 0, 9, 10, 1, 9, 32'h99,     0, 0,  0,             0, 1, 1, 0,  1, 9,  32'h99);
    end else begin
      add("v09", 0, 0, 9, 10, 1, 9, 32'h99,     1, 10, 32'h1010,      0, 1, 1, 0,  1, 9,  32'h99);
      add("v10", 0, 0, 9, 10, 0, 0, 0,          1, 10, 32'h1010,      0, 1, 0, 1,  1, 10, 32'h1010);
    end
    add("v11", 0, 0,  9, 10, 0, 0, 0,            0, 0,  0,             0, 0, 0, 0,  0, w2, d2);
    add("v12", 1, 0,  0, 0,  0, 0, 0,            0, 0,  0,             1, 0, 0, 0,  0, w2, d2);
    add("v13", 0, 0,  0, 0,  0, 0, 0,            0, 0,  0,             0, 0, 0, 0,  0, w2, d2);
    add("v14", 1, 12, 0, 0,  0, 0, 0,            0, 0,  0,             1, 0, 0, 0,  0, w2, d2);
    add("v15", 1, 12, 12, 0, 0, 0, 0,            0, 0,  0,             0, 1, 0, 0,  0, w2, d2);
    add("v16", 1, 12, 12, 0, 1, 12, 32'h12,      0, 0,  0,             0, 1, 1, 0,  1, 12, 32'h12);
    add("v17", 1, 12, 12, 0, 0, 0, 0,            0, 0,  0,             1, 0, 0, 0,  0, 12, 32'h12);
    add("v18", 1, 14, 12, 0, 0, 0, 0,            1, 12, 32'h55,        1, 1, 0, 1,  1, 12, 32'h55);
    add("v19", 0, 0,  14, 12, 0, 0, 0,           0, 0,  0,             0, 1, 0, 0,  0, 12, 32'h55);
    add("v20", 0, 0,  20, 0, 1, 20, 32'h20,      0, 0,  0,             0, 0, 1, 0,  1, 20, 32'h20);
    add("v21", 0, 0,  20, 0, 0, 0, 0,            0, 0,  0,             0, 0, 0, 0,  0, 20, 32'h20);

    // Outputs while reset is held
    #2;
    check("rst.regWrite", 32'(regWrite), 32'd0);
    check("rst.writeRegister", 32'(writeRegister), 32'd0);
    check("rst.writeData", writeData, 32'd0);
    check("rst.hazard", 32'(hazard), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Mid-cycle asynchronous reset with a reservation and a write in flight
    @(negedge clock);
    idle_inputs();
    issueValid = 1; issueRegister = 5'd3;
    @(negedge clock);
    idle_inputs();
    aluValid = 1; aluRegister = 5'd5; aluData = 32'h5A;
    register1 = 5'd3;
    #1;
    check("ar.hazard_pre", 32'(hazard), 32'd1);
    @(posedge clock);
    #1;
    check("ar.regWrite_pre", 32'(regWrite), 32'd1);
    idle_inputs();
    register1 = 5'd3;
    register2 = 5'd14;
    #1;
    reset = 1'b1;
    #1;
    check("ar.regWrite", 32'(regWrite), 32'd0);
    check("ar.writeRegister", 32'(writeRegister), 32'd0);
    check("ar.writeData", writeData, 32'd0);
    check("ar.hazard", 32'(hazard), 32'd0);
    check("ar.aluReady", 32'(aluReady), 32'd0);
    check("ar.memReady", 32'(memReady), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    issueValid = 1; issueRegister = 5'd3;
    #1;
    check("ar.issueReady_after", 32'(issueReady), 32'd1);
    @(negedge clock);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
